diff_window_stats: RTL and testbench
====================================

DIFF_WINDOW_STATS -- requirements
Module: diff_window_stats

Interface
REQ-001 Parameter WIN_LOG2, default 3, log2 of samples per window (N = 2^WIN_LOG2); legal range 1..6.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-004 In  input  8  signed two's-complement difference sample from the upstream counter/difference stage.
REQ-005 In_Valid  input  1  In is a valid sample this cycle; no backpressure to upstream.
REQ-006 Out_Valid  output  1  result registers hold an unconsumed window result.
REQ-007 Out_Ready  input  1  downstream accepts result when high together with Out_Valid.
REQ-008 Sum  output  8+WIN_LOG2  signed sum of the N window samples.
REQ-009 Mean  output  8  signed, Sum arithmetic-shifted right by WIN_LOG2 (floor).
REQ-010 Min / Max  output  8 each  signed minimum / maximum sample of the window.
REQ-011 Drop_Cnt  output  8  unsigned count of completed windows discarded; saturates at 255.

Function
REQ-012 FSM states IDLE and ACCUM; IDLE -> ACCUM on first In_Valid, and that sample is counted.
REQ-013 ACCUM: each In_Valid cycle sign-extends In into an (8+WIN_LOG2)-bit accumulator, increments sample index k, updates running min/max; cycles with In_Valid low change nothing.
REQ-014 Accumulator width guarantees no overflow: N x -128 and N x +127 are exact.
REQ-015 Window completes on the In_Valid cycle with k = N-1; final sum/min/max include that sample.
REQ-016 On completion, if Out_Valid is low or Out_Ready is high that cycle, the result loads into Sum/Mean/Min/Max and Out_Valid is high the next cycle (latency 1 after last sample).
REQ-017 On completion with Out_Valid high and Out_Ready low, the new result is discarded, held outputs stay unchanged, Drop_Cnt increments (saturating at 255).
REQ-018 After completion the accumulator, k and min/max trackers restart; the next In_Valid sample is index 0 of a new window. No samples are lost between windows, and the FSM stays in ACCUM.
REQ-019 Out_Valid falls the cycle after Out_Valid and Out_Ready are both high, unless a new result loads in that same cycle.
REQ-020 Sum/Mean/Min/Max are stable while Out_Valid is high and not accepted.
REQ-021 Out_Ready with Out_Valid low has no effect.

Reset
REQ-022 RST_N low: FSM to IDLE; accumulator, k and Drop_Cnt to 0; Out_Valid 0; Sum, Mean, Min, Max to 0.
REQ-023 Reset mid-window discards the partial window; In_Valid in the reset cycle is ignored.
REQ-024 Reset overrides an Out_Valid and Out_Ready handshake in the same cycle, and the result is lost.

Configuration
REQ-025 Macro DIFF_WINDOW_MINMAX_EN: when defined, min/max tracking is built and Min/Max behave per REQ-010/013.
REQ-026 When DIFF_WINDOW_MINMAX_EN is undefined, no min/max logic is synthesised, Min and Max are constant 0, and all other behaviour is unchanged.

Verification (WIN_LOG2=3, DIFF_WINDOW_MINMAX_EN defined unless stated)
REQ-027 8 consecutive samples of +5, Out_Ready=1 -> one cycle after the 8th: Out_Valid=1, Sum=40, Mean=5, Min=Max=5; Out_Valid=0 the following cycle.
REQ-028 8 samples of -128 -> Sum=-1024, Mean=-128, Min=Max=-128. 8 samples of +127 -> Sum=1016, Mean=127.
REQ-029 Samples -3,7,-10,0,1,-2,4,-6 (sum -9) -> Sum=-9, Mean=-2, Min=-10, Max=7.
REQ-030 Out_Ready held 0 across 3 full windows -> first window's result held unchanged, Drop_Cnt=2. Out_Ready=1 -> Out_Valid drops the next cycle.
REQ-031 In_Valid toggling 1/0 for 16 cycles of +1 then reset asserted after 5 more valid samples, then 8 samples of +2 -> first result Sum=8, post-reset result Sum=16, Drop_Cnt=0.
REQ-032 Build without DIFF_WINDOW_MINMAX_EN, rerun the REQ-029 stimulus -> Sum=-9, Mean=-2, Min=Max=0.

Source files
------------

// File: rtl/diff_window_stats.sv
// diff_window_stats: windowed sum/mean/min/max of signed 8-bit difference samples with drop counting.
// Define DIFF_WINDOW_MINMAX_EN to build min/max tracking; otherwise Min and Max are tied to 0.
module diff_window_stats #(
  parameter int WIN_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            In,
  input  logic                  In_Valid,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [8+WIN_LOG2-1:0] Sum,
  output logic [7:0]            Mean,
  output logic [7:0]            Min,
  output logic [7:0]            Max,
  output logic [7:0]            Drop_Cnt
);
  localparam int W = 8 + WIN_LOG2;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic [W-1:0] acc, nsum;
  logic [WIN_LOG2-1:0] k;
  logic done, load;
  assign nsum = ((state == IDLE) ? '0 : acc) + {{WIN_LOG2{In[7]}}, In};
  assign done = In_Valid && (&k);
  assign load = done && (!Out_Valid || Out_Ready);
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      Out_Valid <= 1'b0;
      Sum       <= '0;
      Mean      <= '0;
      Drop_Cnt  <= '0;
    end else begin
      if (In_Valid) begin
        state <= ACCUM;
        acc   <= done ? '0 : nsum;
        k     <= k + WIN_LOG2'(1);
      end
      if (load) begin
        Sum       <= nsum;
        Mean      <= nsum[W-1:WIN_LOG2];
        Out_Valid <= 1'b1;
      end else if (Out_Valid && Out_Ready)
        Out_Valid <= 1'b0;
      if (done && !load && Drop_Cnt != 8'hff)
        Drop_Cnt <= Drop_Cnt + 8'd1;
    end
  end
`ifdef DIFF_WINDOW_MINMAX_EN
  logic [7:0] mn, mx, nmin, nmax;
  logic first;
  // k wraps to 0 at window end, so stale trackers are ignored by the next window's first sample
  assign first = (state == IDLE) || (k == '0);
  assign nmin  = (first || $signed(In) < $signed(mn)) ? In : mn;
  assign nmax  = (first || $signed(In) > $signed(mx)) ? In : mx;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mn  <= '0;
      mx  <= '0;
      Min <= '0;
      Max <= '0;
    end else begin
      if (In_Valid) begin
        mn <= nmin;
        mx <= nmax;
      end
      if (load) begin
        Min <= nmin;
        Max <= nmax;
      end
    end
  end
`else
  assign Min = '0;
  assign Max = '0;
`endif
endmodule

// File: tb/tb_diff_window_stats.sv
// tb_diff_window_stats: randomized + directed scoreboard bench against a window-level reference model.
module tb_diff_window_stats;
  localparam int WL = 3;
  localparam int N = 1 << WL;
  logic CLK = 0, RST_N = 0, In_Valid = 0, Out_Ready = 0;
  logic [7:0] In = 0;
  logic Out_Valid;
  logic [8+WL-1:0] Sum;
  logic [7:0] Mean, Min, Max, Drop_Cnt;
  typedef struct {int sum; int mean; int mn; int mx;} res_t;
  res_t sb[$];
  int win[$];
  bit m_ov;
  int m_drop;
  int checks = 0, failures = 0;

  diff_window_stats #(.WIN_LOG2(WL)) dut (
    .CLK(CLK), .RST_N(RST_N), .In(In), .In_Valid(In_Valid), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Sum(Sum), .Mean(Mean), .Min(Min), .Max(Max), .Drop_Cnt(Drop_Cnt)
  );

  always #5 CLK = ~CLK;

  function automatic res_t window_result();
    res_t r;
    r.sum = 0;
    r.mn = 127;
    r.mx = -128;
    foreach (win[i]) begin
      r.sum += win[i];
      if (win[i] < r.mn) r.mn = win[i];
      if (win[i] > r.mx) r.mx = win[i];
    end
    r.mean = (r.sum - (((r.sum % N) + N) % N)) / N;
`ifndef DIFF_WINDOW_MINMAX_EN
    r.mn = 0;
    r.mx = 0;
`endif
    return r;
  endfunction

  task automatic step(input bit v, input int d, input bit r, input bit rn);
    bit loaded;
    In = 8'(d);
    In_Valid = v;
    Out_Ready = r;
    RST_N = rn;
    loaded = 0;
    if (!rn) begin
      win.delete();
      sb.delete();
      m_ov = 0;
      m_drop = 0;
    end else begin
      if (v) begin
        win.push_back(int'($signed(8'(d))));
        if (win.size() == N) begin
          if (!m_ov || r) begin
            sb.push_back(window_result());
            loaded = 1;
          end else if (m_drop < 255) m_drop++;
          win.delete();
        end
      end
      if (loaded) m_ov = 1;
      else if (m_ov && r) m_ov = 0;
    end
    @(posedge CLK);
    #1;
    checks++;
    if (Out_Valid !== m_ov) begin
      failures++;
      $display("FAIL out_valid t=%0t got=%b exp=%b", $time, Out_Valid, m_ov);
    end
    checks++;
    if (Drop_Cnt !== 8'(m_drop)) begin
      failures++;
      $display("FAIL drop_cnt t=%0t got=%0d exp=%0d", $time, Drop_Cnt, m_drop);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && Out_Valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result t=%0t sum=%0d", $time, $signed(Sum));
      end else begin
        if (int'($signed(Sum)) != sb[0].sum || int'($signed(Mean)) != sb[0].mean ||
            int'($signed(Min)) != sb[0].mn || int'($signed(Max)) != sb[0].mx) begin
          failures++;
          $display("FAIL result t=%0t got sum=%0d mean=%0d min=%0d max=%0d exp sum=%0d mean=%0d min=%0d max=%0d",
                   $time, $signed(Sum), $signed(Mean), $signed(Min), $signed(Max),
                   sb[0].sum, sb[0].mean, sb[0].mn, sb[0].mx);
        end
        if (Out_Ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int vec29[8] = '{-3, 7, -10, 0, 1, -2, 4, -6};
    step(0, 0, 0, 0);
    step(1, 9, 1, 0);
    checks++;
    if (Sum !== '0 || Mean !== 0 || Min !== 0 || Max !== 0) begin
      failures++;
      $display("FAIL reset_outputs sum=%0d mean=%0d min=%0d max=%0d exp all 0", Sum, Mean, Min, Max);
    end
    for (int i = 0; i < N; i++) step(1, 5, 1, 1);
    repeat (2) step(0, 0, 1, 1);
    for (int i = 0; i < N; i++) step(1, -128, 1, 1);
    repeat (2) step(0, 0, 1, 1);
    for (int i = 0; i < N; i++) step(1, 127, 1, 1);
    repeat (2) step(0, 0, 1, 1);
    for (int i = 0; i < N; i++) step(1, vec29[i], 1, 1);
    repeat (2) step(0, 0, 1, 1);
    for (int i = 0; i < 3 * N; i++) step(1, $urandom_range(255), 0, 1);
    repeat (3) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 1, 1);
    for (int i = 0; i < 16; i++) step(i % 2 == 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1);
    step(1, 1, 1, 0);
    for (int i = 0; i < N; i++) step(1, 2, 1, 1);
    repeat (2) step(0, 0, 1, 1);
    for (int i = 0; i < 258 * N; i++) step(1, $urandom_range(255), 0, 1);
    repeat (2) step(0, 0, 1, 1);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(3) != 0, $urandom_range(255), $urandom_range(2) != 0, $urandom_range(199) != 0);
    repeat (3) step(0, 0, 1, 1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_results got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
